// File: rtl/avalon_arb_pkg.sv
// Shared types for the N:1 Avalon-MM arbiter: FSM states, ID width helper,
// and a default beat-count type.
package avalon_arb_pkg;

    typedef enum logic [1:0] {IDLE, GRANT, WBURST} arb_state_e;

    localparam int BURST_W_DEF = 4;
    typedef logic [BURST_W_DEF-1:0] beat_cnt_t;

    // IDs must be at least one bit wide even for a single master.
    function automatic int id_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/avalon_arb_resp_fifo.sv
// In-order FIFO of {master id, burstcount} for outstanding read commands.
// Push is ignored when full and pop is ignored when empty.
module avalon_arb_resp_fifo
    import avalon_arb_pkg::*;
#(
    parameter int ID_W  = 1,
    parameter int BC_W  = 4,
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [ID_W-1:0] push_id,
    input  logic [BC_W-1:0] push_bc,
    input  logic            pop,
    output logic [ID_W-1:0] head_id,
    output logic [BC_W-1:0] head_bc,
    output logic            full,
    output logic            empty
);
    localparam int PTR_W = $clog2(DEPTH);

    // Extra MSB on each pointer distinguishes full from empty.
    logic [PTR_W:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ID_W-1:0] id_mem_q [DEPTH];
    logic [BC_W-1:0] bc_mem_q [DEPTH];
    logic            do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                     (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head_id = id_mem_q[rd_ptr_q[PTR_W-1:0]];
    assign head_bc = bc_mem_q[rd_ptr_q[PTR_W-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            id_mem_q[wr_ptr_q[PTR_W-1:0]] <= push_id;
            bc_mem_q[wr_ptr_q[PTR_W-1:0]] <= push_bc;
        end
    end

endmodule

// File: rtl/avalon_mm_arbiter_nx1.sv
// Round-robin N:1 Avalon-MM arbiter with locked write bursts and
// read responses steered back to the issuing master through an ID FIFO.
module avalon_mm_arbiter_nx1
    import avalon_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 2,
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int BURST_W     = BURST_W_DEF,
    parameter int MAX_PENDING = 4
) (
    input  logic                            clk_clk,
    input  logic                            reset_reset_n,
    input  logic [NUM_MASTERS*ADDR_W-1:0]   m_address,
    input  logic [NUM_MASTERS-1:0]          m_read,
    input  logic [NUM_MASTERS-1:0]          m_write,
    input  logic [NUM_MASTERS*DATA_W-1:0]   m_writedata,
    input  logic [NUM_MASTERS*DATA_W/8-1:0] m_byteenable,
    input  logic [NUM_MASTERS*BURST_W-1:0]  m_burstcount,
    output logic [NUM_MASTERS-1:0]          m_waitrequest,
    output logic [DATA_W-1:0]               m_readdata,
    output logic [NUM_MASTERS-1:0]          m_readdatavalid,
    output logic [ADDR_W-1:0]               s_address,
    output logic                            s_read,
    output logic                            s_write,
    output logic [DATA_W-1:0]               s_writedata,
    output logic [DATA_W/8-1:0]             s_byteenable,
    output logic [BURST_W-1:0]              s_burstcount,
    input  logic                            s_waitrequest,
    input  logic [DATA_W-1:0]               s_readdata,
    input  logic                            s_readdatavalid,
    output logic                            err
);
    localparam int ID_W = id_w(NUM_MASTERS);
    localparam int BE_W = DATA_W / 8;

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  grant_q, grant_d, rr_q, rr_d;
    logic [BURST_W-1:0] remain_q, remain_d, rbeat_q, rbeat_d;
    logic             err_q, err_d;

    logic [NUM_MASTERS-1:0] req;
    logic [ID_W-1:0]  pick;
    logic             any_req;
    logic             g_read, g_write, rd_blocked, accept, push, pop, rsp_vld;
    logic [BURST_W-1:0] g_bc, head_bc;
    logic [ID_W-1:0]  head_id;
    logic             fifo_full, fifo_empty;

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (int'(id) == NUM_MASTERS - 1) ? '0 : id + 1'b1;
    endfunction

    assign req = m_read | m_write;

    // Scan distances from the far end down so the nearest requester at or
    // after the round-robin pointer wins.
    always_comb begin
        pick    = rr_q;
        any_req = 1'b0;
        for (int k = NUM_MASTERS - 1; k >= 0; k--) begin
            for (int i = 0; i < NUM_MASTERS; i++) begin
                if (req[i] && (i == (int'(rr_q) + k) % NUM_MASTERS)) begin
                    pick    = ID_W'(i);
                    any_req = 1'b1;
                end
            end
        end
    end

    always_comb begin
        s_address    = '0;
        s_writedata  = '0;
        s_byteenable = '0;
        g_bc         = '0;
        g_read       = 1'b0;
        g_write      = 1'b0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (grant_q == ID_W'(i)) begin
                s_address    = m_address[i*ADDR_W +: ADDR_W];
                s_writedata  = m_writedata[i*DATA_W +: DATA_W];
                s_byteenable = m_byteenable[i*BE_W +: BE_W];
                g_bc         = m_burstcount[i*BURST_W +: BURST_W];
                g_read       = m_read[i];
                g_write      = m_write[i];
            end
        end
        s_burstcount = g_bc;
    end

    // A read wins over a write if a master raises both; bursts only carry writes.
    always_comb begin
        s_read        = 1'b0;
        s_write       = 1'b0;
        m_waitrequest = '1;
        rd_blocked    = (state_q == GRANT) & g_read & fifo_full;
        if (state_q == GRANT) begin
            s_read  = g_read & ~fifo_full;
            s_write = g_write & ~g_read;
        end else if (state_q == WBURST) begin
            s_write = g_write;
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (state_q != IDLE && grant_q == ID_W'(i))
                m_waitrequest[i] = rd_blocked | s_waitrequest;
        end
    end

    assign accept = (s_read | s_write) & ~s_waitrequest;
    assign push   = s_read & ~s_waitrequest;

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        remain_d = remain_q;
        case (state_q)
            IDLE: begin
                if (any_req) begin
                    grant_d = pick;
                    state_d = GRANT;
                end
            end
            GRANT: begin
                if (accept) begin
                    if (s_read || g_bc <= BURST_W'(1)) begin
                        state_d = IDLE;
                        rr_d    = next_id(grant_q);
                    end else begin
                        remain_d = g_bc - BURST_W'(1);
                        state_d  = WBURST;
                    end
                end
            end
            WBURST: begin
                if (accept) begin
                    remain_d = remain_q - BURST_W'(1);
                    if (remain_q == BURST_W'(1)) begin
                        state_d = IDLE;
                        rr_d    = next_id(grant_q);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    avalon_arb_resp_fifo #(
        .ID_W  (ID_W),
        .BC_W  (BURST_W),
        .DEPTH (MAX_PENDING)
    ) u_fifo (
        .clk     (clk_clk),
        .rst_n   (reset_reset_n),
        .push    (push),
        .push_id (grant_q),
        .push_bc (g_bc),
        .pop     (pop),
        .head_id (head_id),
        .head_bc (head_bc),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign rsp_vld    = s_readdatavalid & ~fifo_empty;
    assign pop        = rsp_vld & ((rbeat_q + BURST_W'(1)) == head_bc);
    assign m_readdata = s_readdata;
    assign err        = err_q;

    always_comb begin
        m_readdatavalid = '0;
        for (int i = 0; i < NUM_MASTERS; i++)
            m_readdatavalid[i] = rsp_vld & (head_id == ID_W'(i));
        rbeat_d = rbeat_q;
        if (pop)          rbeat_d = '0;
        else if (rsp_vld) rbeat_d = rbeat_q + BURST_W'(1);
        err_d = err_q | (s_readdatavalid & fifo_empty);
    end

    always_ff @(posedge clk_clk) begin
        if (!reset_reset_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_q     <= '0;
            remain_q <= '0;
            rbeat_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            remain_q <= remain_d;
            rbeat_q  <= rbeat_d;
            err_q    <= err_d;
        end
    end

endmodule

// File: tb/tb_avalon_mm_arbiter_nx1.sv
// Directed bench for the N:1 Avalon-MM arbiter with a transaction-level
// reference model checked every cycle plus literal expectations per scenario.
module tb_avalon_mm_arbiter_nx1;
    localparam int NM = 2, AW = 32, DW = 32, BW = 4, MP = 4;

    logic clk_clk = 1'b0, reset_reset_n = 1'b0;
    logic [NM*AW-1:0] m_address = '0;
    logic [NM-1:0] m_read = '0, m_write = '0;
    logic [NM*DW-1:0] m_writedata = '0;
    logic [NM*DW/8-1:0] m_byteenable = '0;
    logic [NM*BW-1:0] m_burstcount = '0;
    logic [NM-1:0] m_waitrequest, m_readdatavalid;
    logic [DW-1:0] m_readdata, s_writedata;
    logic [AW-1:0] s_address;
    logic s_read, s_write, err;
    logic [DW/8-1:0] s_byteenable;
    logic [BW-1:0] s_burstcount;
    logic s_waitrequest = 1'b0, s_readdatavalid = 1'b0;
    logic [DW-1:0] s_readdata = '0;

    avalon_mm_arbiter_nx1 #(.NUM_MASTERS(NM), .ADDR_W(AW), .DATA_W(DW),
                            .BURST_W(BW), .MAX_PENDING(MP)) dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .m_address(m_address), .m_read(m_read), .m_write(m_write),
        .m_writedata(m_writedata), .m_byteenable(m_byteenable),
        .m_burstcount(m_burstcount), .m_waitrequest(m_waitrequest),
        .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_burstcount(s_burstcount), .s_waitrequest(s_waitrequest),
        .s_readdata(s_readdata), .s_readdatavalid(s_readdatavalid), .err(err));

    always #5 clk_clk = ~clk_clk;

    int checks = 0, errors = 0, cyc = 0;
    always @(posedge clk_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- master BFMs ----------------
    typedef struct {bit wr; logic [AW-1:0] addr; logic [BW-1:0] bc; logic [DW-1:0] data;} cmd_t;
    cmd_t cq[NM][$];
    int beat[NM];
    logic [NM-1:0] acc;

    always @(negedge clk_clk) acc = (m_read | m_write) & ~m_waitrequest;

    task automatic present();
        for (int i = 0; i < NM; i++) begin
            if (cq[i].size() > 0) begin
                m_read[i]  = !cq[i][0].wr;
                m_write[i] = cq[i][0].wr;
                m_address[i*AW +: AW]    = cq[i][0].addr;
                m_burstcount[i*BW +: BW] = cq[i][0].bc;
                m_writedata[i*DW +: DW]  = cq[i][0].data + DW'(beat[i]);
                m_byteenable[i*4 +: 4]   = 4'hF - 4'(i);
            end else begin
                m_read[i]  = 1'b0;
                m_write[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_clk); #1;
        for (int i = 0; i < NM; i++) begin
            if (acc[i] && cq[i].size() > 0) begin
                if (cq[i][0].wr && beat[i] + 1 < int'(cq[i][0].bc)) beat[i]++;
                else begin
                    void'(cq[i].pop_front());
                    beat[i] = 0;
                end
            end
        end
        present();
    endtask

    task automatic enq(input int m, input bit wr, input logic [AW-1:0] a,
                       input logic [BW-1:0] bc, input logic [DW-1:0] d);
        cmd_t c;
        c.wr = wr; c.addr = a; c.bc = bc; c.data = d;
        cq[m].push_back(c);
        present();
    endtask

    // ---------------- observation logs ----------------
    int log_m[$], log_w[$], log_c[$];
    logic [NM-1:0] rdv_log[$];

    always @(negedge clk_clk) begin
        if ((s_read | s_write) && !s_waitrequest)
            for (int i = 0; i < NM; i++)
                if (!m_waitrequest[i]) begin
                    log_m.push_back(i);
                    log_w.push_back(int'(s_write));
                    log_c.push_back(cyc);
                end
        if (m_readdatavalid != '0) rdv_log.push_back(m_readdatavalid);
    end

    task automatic clear_logs();
        log_m.delete(); log_w.delete(); log_c.delete(); rdv_log.delete();
    endtask

    // ---------------- reference model ----------------
    typedef struct {int id; int bc;} pend_t;
    pend_t pend[$];
    int own = -1, left = 0, rr_m = 0, rbeat_m = 0;
    bit started = 0, err_m = 0, model_ok = 0;

    always @(negedge clk_clk) begin
        logic [NM-1:0] e_wait, e_rdv;
        bit e_sr, e_sw, rd_cmd, blocked, found;
        int g, nxt;
        pend_t p;
        e_wait = '1; e_rdv = '0; e_sr = 0; e_sw = 0; g = own;
        if (own >= 0) begin
            rd_cmd  = !started && m_read[g];
            blocked = rd_cmd && pend.size() == MP;
            e_sr = rd_cmd && !blocked;
            e_sw = m_write[g] && !rd_cmd;
            e_wait[g] = blocked ? 1'b1 : s_waitrequest;
        end
        if (s_readdatavalid && pend.size() > 0) e_rdv[pend[0].id] = 1'b1;

        if (model_ok) begin
            check("waitrequest", 64'(m_waitrequest), 64'(e_wait));
            check("s_read", 64'(s_read), 64'(e_sr));
            check("s_write", 64'(s_write), 64'(e_sw));
            check("readdatavalid", 64'(m_readdatavalid), 64'(e_rdv));
            check("err", 64'(err), 64'(err_m));
            if (e_sr || e_sw) begin
                check("s_address", 64'(s_address), 64'(m_address[g*AW +: AW]));
                check("s_burstcount", 64'(s_burstcount), 64'(m_burstcount[g*BW +: BW]));
                check("s_byteenable", 64'(s_byteenable), 64'(m_byteenable[g*4 +: 4]));
            end
            if (e_sw) check("s_writedata", 64'(s_writedata), 64'(m_writedata[g*DW +: DW]));
            if (e_rdv != '0) check("m_readdata", 64'(m_readdata), 64'(s_readdata));
        end

        if (!reset_reset_n) begin
            own = -1; started = 0; left = 0; rr_m = 0; rbeat_m = 0; err_m = 0;
            pend.delete(); model_ok = 1;
        end else begin
            if (s_readdatavalid) begin
                if (pend.size() > 0) begin
                    rbeat_m++;
                    if (rbeat_m == pend[0].bc) begin
                        void'(pend.pop_front());
                        rbeat_m = 0;
                    end
                end else err_m = 1;
            end
            if (own < 0) begin
                found = 0;
                for (int k = 0; k < NM; k++) begin
                    nxt = (rr_m + k) % NM;
                    if (!found && (m_read[nxt] || m_write[nxt])) begin
                        own = nxt; started = 0; found = 1;
                    end
                end
            end else if ((e_sr || e_sw) && !s_waitrequest) begin
                if (e_sr) begin
                    p.id = g; p.bc = int'(m_burstcount[g*BW +: BW]);
                    pend.push_back(p);
                    own = -1; rr_m = (g + 1) % NM;
                end else begin
                    if (!started) begin
                        left = int'(m_burstcount[g*BW +: BW]);
                        started = 1;
                    end
                    left--;
                    if (left == 0) begin
                        own = -1; rr_m = (g + 1) % NM;
                    end
                end
            end
        end
    end

    // ---------------- directed scenarios ----------------
    int exp_m1[4] = '{0, 1, 0, 1};
    int exp_c2[5] = '{1, 2, 3, 4, 6};
    logic [NM-1:0] exp_rdv3[3] = '{2'b10, 2'b10, 2'b01};
    int c0, n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        present();
        tick(); tick();
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        check("rst waitrequest", 64'(m_waitrequest), 64'h3);
        check("rst s_read", 64'(s_read), 64'h0);
        check("rst s_write", 64'(s_write), 64'h0);
        check("rst err", 64'(err), 64'h0);

        // 1: both masters stream single writes; grants alternate every 2 cycles
        tick(); clear_logs(); c0 = cyc;
        enq(0, 1, 32'h100, 4'd1, 32'hA000_0000); enq(0, 1, 32'h104, 4'd1, 32'hA000_0001);
        enq(1, 1, 32'h200, 4'd1, 32'hB000_0000); enq(1, 1, 32'h204, 4'd1, 32'hB000_0001);
        repeat (9) tick();
        check("t1 count", 64'(log_m.size()), 64'd4);
        for (int k = 0; k < 4 && k < log_m.size(); k++) begin
            check("t1 grant", 64'(log_m[k]), 64'(exp_m1[k]));
            check("t1 cycle", 64'(log_c[k] - c0), 64'(2 * k + 1));
        end

        // 2: M0 burst of 4 stays locked while M1's read waits
        clear_logs(); c0 = cyc;
        enq(0, 1, 32'h300, 4'd4, 32'hC000_0000);
        tick();
        enq(1, 0, 32'h400, 4'd1, 32'h0);
        repeat (8) tick();
        check("t2 count", 64'(log_m.size()), 64'd5);
        for (int k = 0; k < 5 && k < log_m.size(); k++) begin
            check("t2 master", 64'(log_m[k]), (k == 4) ? 64'd1 : 64'd0);
            check("t2 cycle", 64'(log_c[k] - c0), 64'(exp_c2[k]));
        end
        s_readdatavalid = 1'b1; s_readdata = 32'h1111_0001;
        tick();
        s_readdatavalid = 1'b0;
        check("t2 rdv", (rdv_log.size() > 0) ? 64'(rdv_log[0]) : 64'hx, 64'h2);

        // 3: M1 read bc=2 then M0 read bc=1, responses steered in order
        tick(); clear_logs(); c0 = cyc;
        enq(1, 0, 32'h500, 4'd2, 32'h0);
        tick();
        enq(0, 0, 32'h600, 4'd1, 32'h0);
        repeat (4) tick();
        check("t3 count", 64'(log_m.size()), 64'd2);
        for (int b = 0; b < 3; b++) begin
            s_readdatavalid = 1'b1; s_readdata = 32'hA0 + DW'(b);
            tick();
        end
        s_readdatavalid = 1'b0;
        tick();
        check("t3 rdv count", 64'(rdv_log.size()), 64'd3);
        for (int k = 0; k < 3 && k < rdv_log.size(); k++)
            check("t3 rdv", 64'(rdv_log[k]), 64'(exp_rdv3[k]));
        check("t3 fifo empty", 64'(dut.fifo_empty), 64'h1);

        // 4: fifth outstanding read is held until a response frees a slot
        clear_logs(); c0 = cyc;
        for (int k = 0; k < 5; k++) enq(0, 0, 32'h700 + AW'(4 * k), 4'd1, 32'h0);
        repeat (11) tick();
        @(negedge clk_clk);
        check("t4 held s_read", 64'(s_read), 64'h0);
        check("t4 held wait", 64'(m_waitrequest[0]), 64'h1);
        check("t4 accepted", 64'(log_m.size()), 64'd4);
        tick();
        s_readdatavalid = 1'b1; s_readdata = 32'hD0;
        tick();
        s_readdatavalid = 1'b0;
        repeat (3) tick();
        check("t4 count", 64'(log_m.size()), 64'd5);
        if (log_c.size() == 5) check("t4 fifth cycle", 64'(log_c[4] - c0), 64'd13);
        for (int k = 0; k < 4; k++) begin
            s_readdatavalid = 1'b1; s_readdata = 32'hE0 + DW'(k);
            tick();
        end
        s_readdatavalid = 1'b0;
        tick();

        // 5: stray response with nothing outstanding sets sticky err
        s_readdatavalid = 1'b1; s_readdata = 32'hBAD;
        @(negedge clk_clk);
        check("t5 no rdv", 64'(m_readdatavalid), 64'h0);
        tick();
        s_readdatavalid = 1'b0;
        @(negedge clk_clk);
        check("t5 err set", 64'(err), 64'h1);
        repeat (3) tick();
        @(negedge clk_clk);
        check("t5 err sticky", 64'(err), 64'h1);

        // 6: reset mid-burst after two beats
        tick(); clear_logs(); c0 = cyc;
        enq(0, 1, 32'h800, 4'd4, 32'hF000_0000);
        n = 0;
        while (log_m.size() < 2 && n < 20) begin
            tick(); n++;
        end
        check("t6 two beats", 64'(log_m.size()), 64'd2);
        cq[0].delete(); beat[0] = 0; present();
        reset_reset_n = 1'b0;
        tick();
        reset_reset_n = 1'b1;
        @(negedge clk_clk);
        check("t6 waitrequest", 64'(m_waitrequest), 64'h3);
        check("t6 s_write", 64'(s_write), 64'h0);
        check("t6 err", 64'(err), 64'h0);
        check("t6 rr", 64'(dut.rr_q), 64'h0);
        check("t6 no more beats", 64'(log_m.size()), 64'd2);
        tick(); clear_logs(); c0 = cyc;
        enq(1, 1, 32'h900, 4'd1, 32'h1234_5678);
        repeat (3) tick();
        check("t6 fresh count", 64'(log_m.size()), 64'd1);
        if (log_m.size() == 1) begin
            check("t6 fresh master", 64'(log_m[0]), 64'd1);
            check("t6 fresh cycle", 64'(log_c[0] - c0), 64'd1);
        end

        // 7: slave backpressure stalls the granted master
        clear_logs(); s_waitrequest = 1'b1;
        enq(0, 1, 32'hA00, 4'd1, 32'h5555_0000);
        repeat (4) tick();
        @(negedge clk_clk);
        check("t7 stalled", 64'(log_m.size()), 64'd0);
        check("t7 wait", 64'(m_waitrequest[0]), 64'h1);
        tick();
        s_waitrequest = 1'b0;
        repeat (2) tick();
        check("t7 released", 64'(log_m.size()), 64'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
